// File: rtl/array_stream_serializer_pkg.sv
// Shared constants, sizing helpers and FSM states for array_stream_serializer.
package array_stream_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } state_e;

  // Output beat width in bits for a given number of bytes per beat.
  function automatic int unsigned beat_w(input int unsigned replication_factor);
    return 8 * replication_factor;
  endfunction

  // Snapshot width in bits.
  function automatic int unsigned total_w(input int unsigned array_width,
                                          input int unsigned array_height,
                                          input int unsigned cell_width);
    return array_width * array_height * cell_width;
  endfunction

  // Beats needed to carry one snapshot (ceiling division).
  function automatic int unsigned num_beats(input int unsigned tot_w,
                                            input int unsigned bt_w);
    return (tot_w + bt_w - 1) / bt_w;
  endfunction

endpackage

// File: rtl/array_stream_serializer_if.sv
// Wide snapshot input and narrow beat output of the serializer.
interface array_stream_serializer_if #(
  parameter int unsigned TOTAL_W = 384,
  parameter int unsigned BEAT_W  = 24
);

  logic [TOTAL_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [BEAT_W-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

// File: rtl/array_stream_serializer.sv
// Serializes one wide array snapshot into LSB-first narrow valid/ready/last beats.
// Optional macro ARRAY_STREAM_SERIALIZER_HEADER_EN prefixes each snapshot with a
// header beat carrying the data beat count.
module array_stream_serializer
  import array_stream_serializer_pkg::*;
#(
  parameter int unsigned REPLICATION_FACTOR = 3,
  parameter int unsigned ARRAY_HEIGHT       = 16,
  parameter int unsigned ARRAY_WIDTH        = 3,
  parameter int unsigned CELL_WIDTH         = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  array_stream_serializer_if.slave  bus
);

  localparam int unsigned BEAT_W    = beat_w(REPLICATION_FACTOR);
  localparam int unsigned TOTAL_W   = total_w(ARRAY_WIDTH, ARRAY_HEIGHT, CELL_WIDTH);
  localparam int unsigned NUM_BEATS = num_beats(TOTAL_W, BEAT_W);
  localparam int unsigned PAD_W     = NUM_BEATS * BEAT_W;
  localparam int unsigned CNT_W     = ($clog2(NUM_BEATS + 1) > 1) ? $clog2(NUM_BEATS + 1) : 1;
  localparam int unsigned IDX_W     = ($clog2(NUM_BEATS) > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [NUM_BEATS-1:0][BEAT_W-1:0] shadow_q, shadow_d;

  logic              out_valid_c;
  logic              out_last_c;
  logic              in_ready_c;
  logic              load_c;
  logic [BEAT_W-1:0] out_data_c;
  logic              unused_in_last;

  // Each snapshot is a full transaction on its own; the input last flag carries no information.
  assign unused_in_last = bus.in_last;

  // State, beat counter and zero-padded snapshot shadow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
    end
  end

  // Handshake decode and next-state logic; a load on the final beat chains the next snapshot.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    out_valid_c = (state_q != IDLE);
    out_last_c  = (state_q == SEND) && (cnt_q == LAST_CNT);
    in_ready_c  = reset && enable &&
                  ((state_q == IDLE) || (out_valid_c && bus.out_ready && out_last_c));
    load_c      = bus.in_valid && in_ready_c;

    case (state_q)
      HDR: begin
        if (bus.out_ready) begin
          state_d = SEND;
          cnt_d   = '0;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (out_last_c) state_d = IDLE;
          else            cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (load_c) begin
      shadow_d = PAD_W'(bus.in_data);
      cnt_d    = '0;
`ifdef ARRAY_STREAM_SERIALIZER_HEADER_EN
      state_d  = HDR;
`else
      state_d  = SEND;
`endif
    end
  end

  // Indexed beat select keeps the presented beat stable while stalled.
  always_comb begin
    out_data_c = shadow_q[IDX_W'(cnt_q)];
    if (state_q == HDR) out_data_c = BEAT_W'(NUM_BEATS);
  end

  assign bus.out_valid = out_valid_c;
  assign bus.out_last  = out_last_c;
  assign bus.out_data  = out_data_c;
  assign bus.in_ready  = in_ready_c;

endmodule
